// File: rtl/sched_pkg.sv
// Shared types and constants for the preemptive process scheduler.
package sched_pkg;

  typedef enum logic [1:0] {
    StRun,
    StSave,
    StSelect,
    StRestore
  } sched_state_e;

  typedef enum logic [1:0] {
    EvDone,
    EvSwap,
    EvExpire
  } sched_event_e;

  localparam int unsigned KERNEL_PID  = 0;
  localparam int unsigned QUANTUM_MIN = 2;

  // A pid field is at least one bit wide, even for two slots.
  function automatic int unsigned pid_width(input int unsigned num_procs);
    return (num_procs > 2) ? $clog2(num_procs) : 1;
  endfunction

endpackage

// File: rtl/rr_next_active.sv
// Round-robin search: next set bit after ptr_i with wrap-around, bit 0 and ptr_i excluded.
module rr_next_active #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [Width-1:0] vec_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             found_o
);

  localparam int W = int'(Width);

  int cand;

  // Walk offsets from farthest to nearest so the closest hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int off = W - 1; off >= 1; off--) begin
      cand = (int'(ptr_i) + off) % W;
      if (cand != 0 && vec_i[cand]) begin
        idx_o   = IdxW'(cand);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/proc_scheduler.sv
// Preemptive round-robin process scheduler with saved-PC table and PC/interrupt strobes.
// Define SCHED_QUANTUM_PROG_EN to add a runtime-programmable quantum register.
module proc_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NUM_PROCS = 4,
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned QUANTUM   = 64,
  parameter int unsigned PID_WIDTH = pid_width(NUM_PROCS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 hlt,
  input  logic [PC_WIDTH-1:0]  cur_pc,
  input  logic                 proc_swap,
  input  logic [31:0]          new_proc_num,
  input  logic                 proc_done,
  input  logic                 proc_create,
  input  logic [PID_WIDTH-1:0] create_pid,
  input  logic [PC_WIDTH-1:0]  create_pc,
`ifdef SCHED_QUANTUM_PROG_EN
  input  logic                 quantum_wr,
  input  logic [15:0]          quantum_in,
`endif
  output logic                 busy,
  output logic [PID_WIDTH-1:0] exec_proc,
  output logic                 pc_load,
  output logic [PC_WIDTH-1:0]  next_pc,
  output logic                 intrpt,
  output logic [31:0]          intrpt_val,
  output logic                 swap_err
);

  sched_state_e         state_q, state_d;
  sched_event_e         evt_q, evt_d;
  logic [PID_WIDTH-1:0] exec_q, exec_d;
  logic [PID_WIDTH-1:0] target_q, target_d;
  logic [NUM_PROCS-1:0] active_q, active_d;
  logic [PC_WIDTH-1:0]  tbl_q [NUM_PROCS];
  logic [PC_WIDTH-1:0]  tbl_d [NUM_PROCS];
  logic [15:0]          cnt_q, cnt_d;
  logic                 swap_err_q, swap_err_d;
  logic                 cnt_clr;
  logic [15:0]          quant_eff;

`ifdef SCHED_QUANTUM_PROG_EN
  logic [15:0] quantum_q, quantum_d;
  logic [15:0] quant_act_q, quant_act_d;

  always_comb begin
    quantum_d = quantum_q;
    if (quantum_wr) begin
      quantum_d = (quantum_in < 16'(QUANTUM_MIN)) ? 16'(QUANTUM_MIN) : quantum_in;
    end
    // A new quantum only takes effect when the counter next restarts.
    quant_act_d = cnt_clr ? quantum_q : quant_act_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quantum_q   <= 16'(QUANTUM);
      quant_act_q <= 16'(QUANTUM);
    end else begin
      quantum_q   <= quantum_d;
      quant_act_q <= quant_act_d;
    end
  end

  assign quant_eff = quant_act_q;
`else
  assign quant_eff = 16'(QUANTUM);
`endif

  logic [PID_WIDTH-1:0] rr_idx;
  logic                 rr_found;

  rr_next_active #(
    .Width(NUM_PROCS),
    .IdxW (PID_WIDTH)
  ) u_rr_next_active (
    .vec_i  (active_q),
    .ptr_i  (exec_q),
    .idx_o  (rr_idx),
    .found_o(rr_found)
  );

  logic [PID_WIDTH-1:0] swap_pid;
  logic                 swap_ok;
  logic                 count_en;
  logic                 at_limit;
  logic                 create_ok;

  assign swap_pid  = new_proc_num[PID_WIDTH-1:0];
  assign swap_ok   = (new_proc_num < 32'(NUM_PROCS)) && active_q[swap_pid] &&
                     (swap_pid != exec_q);
  assign count_en  = (exec_q != PID_WIDTH'(KERNEL_PID)) && !hlt;
  assign at_limit  = (cnt_q == quant_eff - 16'd1);
  assign create_ok = proc_create && (create_pid != PID_WIDTH'(KERNEL_PID)) &&
                     (32'(create_pid) < 32'(NUM_PROCS)) && (create_pid != exec_q);

  always_comb begin
    state_d    = state_q;
    evt_d      = evt_q;
    exec_d     = exec_q;
    target_d   = target_q;
    active_d   = active_q;
    tbl_d      = tbl_q;
    cnt_d      = cnt_q;
    swap_err_d = 1'b0;
    cnt_clr    = 1'b0;

    unique case (state_q)
      StRun: begin
        // Holding at the limit keeps a deferred expiry pending.
        if (count_en && !at_limit) cnt_d = cnt_q + 16'd1;
        if (proc_done) begin
          evt_d   = EvDone;
          state_d = StSave;
        end else if (proc_swap) begin
          if (swap_ok) begin
            evt_d    = EvSwap;
            target_d = swap_pid;
            state_d  = StSave;
          end else begin
            swap_err_d = 1'b1;
          end
        end else if (count_en && at_limit) begin
          if (rr_found) begin
            evt_d   = EvExpire;
            state_d = StSave;
          end else begin
            cnt_clr = 1'b1;
          end
        end
      end
      StSave: begin
        if (evt_q != EvDone) begin
          tbl_d[exec_q] = cur_pc;
        end else if (exec_q != PID_WIDTH'(KERNEL_PID)) begin
          active_d[exec_q] = 1'b0;
        end
        state_d = StSelect;
      end
      StSelect: begin
        if (evt_q != EvSwap) target_d = rr_found ? rr_idx : PID_WIDTH'(KERNEL_PID);
        state_d = StRestore;
      end
      StRestore: begin
        exec_d  = target_q;
        cnt_clr = 1'b1;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    if (cnt_clr) cnt_d = '0;

    if (create_ok) begin
      tbl_d[create_pid]    = create_pc;
      active_d[create_pid] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StRun;
      evt_q      <= EvSwap;
      exec_q     <= '0;
      target_q   <= '0;
      active_q   <= NUM_PROCS'(1);
      cnt_q      <= '0;
      swap_err_q <= 1'b0;
      for (int i = 0; i < int'(NUM_PROCS); i++) tbl_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      evt_q      <= evt_d;
      exec_q     <= exec_d;
      target_q   <= target_d;
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      swap_err_q <= swap_err_d;
      tbl_q      <= tbl_d;
    end
  end

  assign busy       = (state_q != StRun);
  assign exec_proc  = exec_q;
  assign pc_load    = (state_q == StRestore);
  assign intrpt     = (state_q == StRestore);
  assign next_pc    = (state_q == StRestore) ? tbl_q[target_q] : '0;
  assign intrpt_val = (state_q == StRestore) ? 32'(target_q) : 32'd0;
  assign swap_err   = swap_err_q;

endmodule

// File: tb/tb_proc_scheduler.sv
// Directed bench for proc_scheduler with default parameters (NUM_PROCS=4, QUANTUM=64).
module tb_proc_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hlt = 1'b0;
  logic [9:0]  cur_pc = '0;
  logic        proc_swap = 1'b0;
  logic [31:0] new_proc_num = '0;
  logic        proc_done = 1'b0;
  logic        proc_create = 1'b0;
  logic [1:0]  create_pid = '0;
  logic [9:0]  create_pc = '0;
  logic        busy;
  logic [1:0]  exec_proc;
  logic        pc_load;
  logic [9:0]  next_pc;
  logic        intrpt;
  logic [31:0] intrpt_val;
  logic        swap_err;
`ifdef SCHED_QUANTUM_PROG_EN
  logic        quantum_wr = 1'b0;
  logic [15:0] quantum_in = '0;
`endif

  proc_scheduler u_dut (
    .clock       (clock),
    .reset       (reset),
    .hlt         (hlt),
    .cur_pc      (cur_pc),
    .proc_swap   (proc_swap),
    .new_proc_num(new_proc_num),
    .proc_done   (proc_done),
    .proc_create (proc_create),
    .create_pid  (create_pid),
    .create_pc   (create_pc),
`ifdef SCHED_QUANTUM_PROG_EN
    .quantum_wr  (quantum_wr),
    .quantum_in  (quantum_in),
`endif
    .busy        (busy),
    .exec_proc   (exec_proc),
    .pc_load     (pc_load),
    .next_pc     (next_pc),
    .intrpt      (intrpt),
    .intrpt_val  (intrpt_val),
    .swap_err    (swap_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic create(input logic [1:0] pid, input logic [9:0] pc);
    proc_create = 1'b1;
    create_pid  = pid;
    create_pc   = pc;
    tick();
    proc_create = 1'b0;
  endtask

  // Leaves the bench at the negedge of the cycle after acceptance (SAVE or swap_err).
  task automatic do_swap(input logic [31:0] pid);
    new_proc_num = pid;
    proc_swap    = 1'b1;
    tick();
    proc_swap = 1'b0;
  endtask

  task automatic do_done();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
  endtask

  task automatic wait_load(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (pc_load !== 1'b1 && n < max);
  endtask

  task automatic check_restore(input string tag, input logic [9:0] pc, input logic [31:0] pid);
    check_eq({tag, "_pc_load"}, 32'(pc_load), 32'd1);
    check_eq({tag, "_intrpt"}, 32'(intrpt), 32'd1);
    check_eq({tag, "_next_pc"}, 32'(next_pc), 32'(pc));
    check_eq({tag, "_intrpt_val"}, intrpt_val, pid);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int strobes;

    repeat (2) tick();
    check_eq("rst_exec", 32'(exec_proc), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pc_load", 32'(pc_load), 32'd0);
    check_eq("rst_intrpt", 32'(intrpt), 32'd0);
    check_eq("rst_next_pc", 32'(next_pc), 32'd0);
    check_eq("rst_intrpt_val", intrpt_val, 32'd0);
    check_eq("rst_swap_err", 32'(swap_err), 32'd0);
    reset = 1'b0;

    // Kernel alone is never preempted.
    strobes = 0;
    repeat (20) begin
      tick();
      if (pc_load || intrpt || busy || swap_err) strobes++;
    end
    check_eq("idle_strobes", 32'(strobes), 32'd0);
    check_eq("idle_exec", 32'(exec_proc), 32'd0);

    cur_pc = 10'h011;
    create(2'd1, 10'h040);
    create(2'd2, 10'h080);
    do_swap(32'd1);
    check_eq("swap1_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check_restore("swap1", 10'h040, 32'd1);

    cur_pc = 10'h055;
    wait_load(100, n);
    check_eq("q1_latency", 32'(n), 32'd67);
    check_restore("q1", 10'h080, 32'd2);

    cur_pc = 10'h09A;
    wait_load(100, n);
    check_eq("q2_latency", 32'(n), 32'd67);
    check_restore("q2", 10'h055, 32'd1);

    cur_pc = 10'h0C3;
    wait_load(100, n);
    check_eq("q3_latency", 32'(n), 32'd67);
    check_restore("q3_wrap", 10'h09A, 32'd2);

    // pid2 exits: search from 2 wraps past slot 0 to pid1.
    tick();
    check_eq("run2_exec", 32'(exec_proc), 32'd2);
    do_done();
    tick();
    tick();
    check_restore("done2", 10'h0C3, 32'd1);
    tick();

    // pid1 alone: expiry wraps the counter without a switch.
    strobes = 0;
    repeat (140) begin
      tick();
      if (pc_load || busy) strobes++;
    end
    check_eq("solo_strobes", 32'(strobes), 32'd0);
    check_eq("solo_exec", 32'(exec_proc), 32'd1);

    do_done();
    tick();
    tick();
    check_restore("done1", 10'h011, 32'd0);
    tick();
    check_eq("kernel_exec", 32'(exec_proc), 32'd0);

    do_swap(32'd1);
    check_eq("rej_inactive_err", 32'(swap_err), 32'd1);
    check_eq("rej_inactive_busy", 32'(busy), 32'd0);
    tick();
    check_eq("rej_pulse_end", 32'(swap_err), 32'd0);
    check_eq("rej_inactive_exec", 32'(exec_proc), 32'd0);

    do_swap(32'd7);
    check_eq("rej_range_err", 32'(swap_err), 32'd1);
    check_eq("rej_range_busy", 32'(busy), 32'd0);
    tick();
    do_swap(32'd0);
    check_eq("rej_self_err", 32'(swap_err), 32'd1);
    check_eq("rej_self_busy", 32'(busy), 32'd0);
    tick();

    // hlt for 30 cycles stretches the quantum by exactly 30.
    cur_pc = 10'h022;
    create(2'd1, 10'h100);
    create(2'd3, 10'h180);
    do_swap(32'd1);
    tick();
    tick();
    check_restore("swap1b", 10'h100, 32'd1);
    repeat (10) tick();
    hlt = 1'b1;
    repeat (30) tick();
    hlt = 1'b0;
    wait_load(200, n);
    check_eq("hlt_latency", 32'(n + 40), 32'd97);
    check_restore("hlt_q", 10'h180, 32'd3);

    // Reset during SELECT aborts the sequence.
    tick();
    cur_pc = 10'h1AA;
    do_swap(32'd1);
    tick();
    check_eq("sel_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rst2_exec", 32'(exec_proc), 32'd0);
    check_eq("rst2_busy", 32'(busy), 32'd0);
    check_eq("rst2_pc_load", 32'(pc_load), 32'd0);
    check_eq("rst2_intrpt", 32'(intrpt), 32'd0);
    check_eq("rst2_next_pc", 32'(next_pc), 32'd0);
    check_eq("rst2_intrpt_val", intrpt_val, 32'd0);
    reset = 1'b0;
    do_swap(32'd1);
    check_eq("rst2_active_cleared", 32'(swap_err), 32'd1);
    check_eq("rst2_no_busy", 32'(busy), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/proc_scheduler.md
Name: proc_scheduler

Overview:
- Parametrised preemptive process scheduler. Successor to the single-swap process keeper and interruption logic in the core.
- Holds a saved-PC table for NUM_PROCS processes. Process 0 is the kernel/OS.
- Time-slices user processes round-robin using a quantum counter, and also services explicit swap and process-exit requests.
- Drives the PC load path and the interrupt signalling into the register bank.

Parameters:
- NUM_PROCS, 4, process slots including kernel slot 0; minimum 2.
- PC_WIDTH, 10, width of stored and loaded PC values.
- QUANTUM, 64, user-process time slice in clock cycles; minimum 2.
- PID_WIDTH, $clog2(NUM_PROCS), process id width (derived).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hlt  in  1  core halted; freezes the quantum counter
- cur_pc  in  PC_WIDTH  PC of the running process, saved on switch-out
- proc_swap  in  1  explicit switch request (swap instruction)
- new_proc_num  in  32  target pid for proc_swap; bits [PID_WIDTH-1:0] are used
- proc_done  in  1  running process exits
- proc_create  in  1  register a process
- create_pid  in  PID_WIDTH  slot written by proc_create
- create_pc  in  PC_WIDTH  start PC for create_pid
- busy  out  1  switch sequence in progress
- exec_proc  out  PID_WIDTH  currently running pid
- pc_load  out  1  one-cycle strobe: PC must load next_pc
- next_pc  out  PC_WIDTH  restored PC
- intrpt  out  1  one-cycle strobe coincident with pc_load
- intrpt_val  out  32  zero-extended pid being switched in
- swap_err  out  1  one-cycle strobe: swap rejected

Behaviour:
- Reset:
  - exec_proc=0, all table PCs=0, active[0]=1, all other active bits=0.
  - Counter=0, state RUN; busy, pc_load, intrpt, swap_err=0; next_pc=0; intrpt_val=0.
- States: RUN, SAVE, SELECT, RESTORE. busy=1 in all states except RUN.
- Event sampling in RUN only. Priority: proc_done > proc_swap > quantum expiry.
- Events asserted while busy are ignored; requesters hold them until busy=0.
- Quantum counter:
  - Increments in RUN when exec_proc!=0 and hlt=0. Holds while hlt=1.
  - Expiry is when the counter equals QUANTUM-1.
  - The counter clears on every entry to RUN. The kernel (pid 0) is never timer-preempted.
- Event accepted at edge T:
  - Cycle T+1 is SAVE: table[exec_proc]<=cur_pc. On proc_done, the PC save is skipped and active[exec_proc] is cleared.
  - Cycle T+2 is SELECT: the target is chosen.
  - Cycle T+3 is RESTORE: pc_load=1, intrpt=1, next_pc=table[target], intrpt_val=target; exec_proc is updated at the end of this cycle.
  - Cycle T+4 is RUN.
- Target selection:
  - proc_swap: target = new_proc_num[PID_WIDTH-1:0].
  - Expiry or done: the first active pid in 1..NUM_PROCS-1 searching upward from exec_proc+1, with wrap-around. Slot 0 is excluded from the search.
  - Done with no other active user pid: target = 0 (kernel).
- Swap rejection:
  - Condition: new_proc_num >= NUM_PROCS, the target is inactive, or the target equals exec_proc.
  - swap_err pulses one cycle at T+1 and the state stays RUN. No save occurs and the counter is unaffected.
- Expiry with no other active user pid: no switch; the counter wraps to 0 and no strobes are raised.
- proc_create:
  - Accepted in any state: table[create_pid]<=create_pc, active<=1.
  - Ignored when create_pid==0, create_pid>=NUM_PROCS, or create_pid==exec_proc.
  - A create for the pid selected in SELECT that arrives before RESTORE updates the PC restored in RESTORE. The table write is visible the next cycle.
- A hlt change mid-sequence does not stall the sequence.
- Reset mid-sequence aborts it immediately and applies the reset values.

Optional Feature:
- Macro: SCHED_QUANTUM_PROG_EN.
- When defined:
  - Adds ports quantum_wr (in, 1) and quantum_in (in, 16).
  - A runtime quantum register, reset to QUANTUM, is loaded when quantum_wr=1.
  - quantum_in values below 2 are clamped to 2.
  - The new value takes effect from the next counter clear.
- When undefined: the quantum is the fixed parameter QUANTUM and the ports are absent.

Decomposition:
- Package sched_pkg holds:
  - the state enum (RUN, SAVE, SELECT, RESTORE);
  - the KERNEL_PID=0 constant;
  - the QUANTUM_MIN=2 constant;
  - a pid_width function.
- One sub-module, rr_next_active: combinational search returning the next set bit above a pointer, with wrap, excluding bit 0, plus a found flag.

Test Plan:
- Reset, then 20 cycles idle -> exec_proc=0, no strobes; kernel is never preempted.
- Create pid1 pc=0x040 and pid2 pc=0x080; swap to 1 -> pc_load at T+3 with next_pc=0x040, intrpt_val=1. After QUANTUM=64 cycles with cur_pc=0x055 -> switch to pid2 with next_pc=0x080.
- After that quantum, pid2 expires with cur_pc=0x09A -> pid1 restored at 0x055. Next expiry -> pid2 restored at 0x09A (round-robin wrap).
- pid1 running alone, proc_done -> intrpt_val=0, next_pc=table[0], active[1]=0. Subsequent swap to 1 -> swap_err pulse, exec_proc stays 0.
- Swap with new_proc_num=7 (NUM_PROCS=4), and swap to the running pid -> swap_err each time, busy stays 0.
- hlt=1 for 30 cycles mid-quantum -> expiry delayed by exactly 30 cycles. Reset asserted during SELECT -> all outputs at reset values the next cycle.
